// File: rtl/sync_bus_arbiter_if.sv
// Bundle between local requesters and the shared CDC synchronizer bus.
// The arbiter takes the master modport; requesters and the destination side use slave.
interface sync_bus_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4
) ();

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic [DATA_WIDTH-1:0]         bus_data;
    logic                          bus_en;
    logic [ID_W-1:0]               bus_id;
    logic                          busy;

    modport master (
        input  req,
        input  req_data,
        output gnt,
        output bus_data,
        output bus_en,
        output bus_id,
        output busy
    );

    modport slave (
        output req,
        output req_data,
        input  gnt,
        input  bus_data,
        input  bus_en,
        input  bus_id,
        input  busy
    );

endinterface

// File: rtl/sync_bus_arbiter.sv
// Round-robin scheduler sharing one data+enable CDC synchronizer bus among NUM_REQ requesters.
// Optional macro SYNC_BUS_PRIO_EN: requester 0 gets fixed top priority, the rest share round-robin.
module sync_bus_arbiter #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 3
) (
    input  logic               clk,
    input  logic               rst,
    sync_bus_arbiter_if.master bus
);

    localparam int unsigned ID_W    = $clog2(NUM_REQ);
    localparam int unsigned MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [ID_W-1:0]  LAST_RST  = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ID_W-1:0]        last_q, last_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic [DATA_WIDTH-1:0]  bus_data_q, bus_data_d;
    logic                   bus_en_q, bus_en_d;
    logic [ID_W-1:0]        bus_id_q, bus_id_d;
    logic                   busy_q, busy_d;

    logic                   win_valid;
    logic                   win_upd;
    logic [ID_W-1:0]        win_idx;
    logic [ID_W-1:0]        cand;
    logic [DATA_WIDTH-1:0]  words [NUM_REQ];

    // Unpack the flat request data bus into per-requester words.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
        assign words[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Winner search: first set request after the last grant, wrapping modulo NUM_REQ.
    always_comb begin
        win_valid = 1'b0;
        win_upd   = 1'b0;
        win_idx   = '0;
        cand      = '0;
`ifdef SYNC_BUS_PRIO_EN
        if (bus.req[0]) begin
            // Fixed-priority winner leaves the round-robin pointer untouched.
            win_valid = 1'b1;
        end else begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                cand = ID_W'((32'(last_q) + k) % NUM_REQ);
                if (!win_valid && (cand != '0) && bus.req[cand]) begin
                    win_valid = 1'b1;
                    win_upd   = 1'b1;
                    win_idx   = cand;
                end
            end
        end
`else
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(last_q) + k) % NUM_REQ);
            if (!win_valid && bus.req[cand]) begin
                win_valid = 1'b1;
                win_upd   = 1'b1;
                win_idx   = cand;
            end
        end
`endif
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        gnt_d      = '0;
        bus_data_d = bus_data_q;
        bus_en_d   = bus_en_q;
        bus_id_d   = bus_id_q;
        busy_d     = busy_q;

        unique case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    gnt_d      = NUM_REQ'(1) << win_idx;
                    bus_data_d = words[win_idx];
                    bus_id_d   = win_idx;
                    bus_en_d   = 1'b1;
                    busy_d     = 1'b1;
                    cnt_d      = HOLD_LOAD;
                    state_d    = ST_HOLD;
                    if (win_upd) begin
                        last_d = win_idx;
                    end
                end
            end
            ST_HOLD: begin
                bus_en_d = 1'b1;
                if (cnt_q == '0) begin
                    bus_en_d = 1'b0;
                    cnt_d    = GAP_LOAD;
                    state_d  = ST_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                // The low gap guarantees the destination sees a fresh enable edge.
                bus_en_d = 1'b0;
                if (cnt_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                bus_en_d = 1'b0;
                busy_d   = 1'b0;
                cnt_d    = '0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            last_q     <= LAST_RST;
            gnt_q      <= '0;
            bus_data_q <= '0;
            bus_en_q   <= 1'b0;
            bus_id_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            bus_data_q <= bus_data_d;
            bus_en_q   <= bus_en_d;
            bus_id_q   <= bus_id_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.bus_data = bus_data_q;
    assign bus.bus_en   = bus_en_q;
    assign bus.bus_id   = bus_id_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_sync_bus_arbiter.sv
// Self-checking bench for sync_bus_arbiter: directed steps plus random traffic against a
// transfer-level reference model, and a loopback through a 3-flop synchronizer on a slower clock.
`timescale 1ns/1ps
module tb_sync_bus_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int H  = 4;
    localparam int G  = 3;

    logic clk;
    logic clk2;
    logic rst;

    sync_bus_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) ifc ();

    sync_bus_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .HOLD_CYCLES(H),
        .GAP_CYCLES (G)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial clk2 = 1'b0;
    always #7.143 clk2 = ~clk2;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cyc    = 0;

    // Reference model: phase counts cycles since the grant edge, -1 when idle.
    int              m_phase = -1;
    int              m_last  = NR - 1;
    logic [NR-1:0]   m_gnt   = '0;
    logic [DW-1:0]   m_data  = '0;
    int              m_id    = 0;
    logic [DW-1:0]   tx_q [$];
    logic [DW-1:0]   rx_q [$];

    // Destination domain: 3-flop enable synchronizer, word captured on the synchronized rising edge.
    logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0, s3_d = 1'b0;
    always @(posedge clk2) begin
        s1   <= ifc.bus_en;
        s2   <= s1;
        s3   <= s2;
        s3_d <= s3;
        if (s3 && !s3_d) rx_q.push_back(ifc.bus_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic pick(input logic [NR-1:0] r, input int last,
                        output bit found, output int w, output bit upd);
        found = 1'b0;
        w     = 0;
        upd   = 1'b0;
`ifdef SYNC_BUS_PRIO_EN
        if (r[0]) begin
            found = 1'b1;
            return;
        end
        for (int k = 1; k <= NR; k++) begin
            int c;
            c = (last + k) % NR;
            if (!found && c != 0 && r[c]) begin
                found = 1'b1; w = c; upd = 1'b1;
            end
        end
`else
        for (int k = 1; k <= NR; k++) begin
            int c;
            c = (last + k) % NR;
            if (!found && r[c]) begin
                found = 1'b1; w = c; upd = 1'b1;
            end
        end
`endif
    endtask

    task automatic model_edge();
        bit found;
        bit upd;
        int w;
        if (rst) begin
            m_phase = -1; m_last = NR - 1; m_gnt = '0; m_data = '0; m_id = 0;
        end else if (m_phase < 0) begin
            pick(ifc.req, m_last, found, w, upd);
            if (found) begin
                m_gnt   = NR'(1 << w);
                m_data  = ifc.req_data[w*DW +: DW];
                m_id    = w;
                m_phase = 0;
                if (upd) m_last = w;
                tx_q.push_back(m_data);
            end else begin
                m_gnt = '0;
            end
        end else begin
            m_gnt = '0;
            m_phase++;
            if (m_phase >= H + G) m_phase = -1;
        end
    endtask

    // One clock: update the model from inputs seen at the edge, then compare all outputs.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check("gnt",      32'(ifc.gnt),      32'(m_gnt));
        check("bus_en",   32'(ifc.bus_en),   32'(m_phase >= 0 && m_phase < H));
        check("busy",     32'(ifc.busy),     32'(m_phase >= 0));
        check("bus_data", 32'(ifc.bus_data), 32'(m_data));
        check("bus_id",   32'(ifc.bus_id),   32'(m_id));
    endtask

    task automatic gid(output int id);
        id = -1;
        for (int i = 0; i < NR; i++) if (ifc.gnt[i]) id = i;
    endtask

    initial begin
        int g_ids [$];
        int g_cyc [$];
        int en_cnt;
        int busy_cnt;
        int prev_id;
        int id;
        int issued;

        rst = 1'b1;
        ifc.req = '1;
        ifc.req_data = {8'h44, 8'h33, 8'h22, 8'h11};

        // Reset held two cycles with all requests high.
        step();
        step();
        check("rst_gnt", 32'(ifc.gnt), 32'h0);
        check("rst_en",  32'(ifc.bus_en), 32'h0);

        // Continuous requests: first grant to 0, then 8-cycle spacing.
        rst = 1'b0;
        step();
        check("first_gnt", 32'(ifc.gnt), 32'h1);
        check("first_data", 32'(ifc.bus_data), 32'h11);
        for (int n = 0; n < 32; n++) begin
            step();
            gid(id);
            if (id >= 0) begin
                g_ids.push_back(id);
                g_cyc.push_back(n + 1);
            end
        end
        check("rr_count", 32'(g_ids.size()), 32'd4);
        for (int i = 0; i < g_ids.size() && i < 4; i++) begin
`ifdef SYNC_BUS_PRIO_EN
            check("rr_id", 32'(g_ids[i]), 32'd0);
`else
            check("rr_id", 32'(g_ids[i]), 32'((i + 1) % NR));
`endif
            check("rr_spacing", 32'(g_cyc[i]), 32'(8 * (i + 1)));
        end
        ifc.req = '0;
        for (int n = 0; n < 10; n++) step();

        // Single request from requester 2.
        ifc.req_data[2*DW +: DW] = 8'hA5;
        ifc.req = 4'b0100;
        step();
        check("single_gnt",  32'(ifc.gnt), 32'h4);
        check("single_data", 32'(ifc.bus_data), 32'hA5);
        check("single_id",   32'(ifc.bus_id), 32'd2);
        ifc.req = '0;
        en_cnt   = int'(ifc.bus_en);
        busy_cnt = int'(ifc.busy);
        for (int n = 0; n < 10; n++) begin
            step();
            en_cnt   += int'(ifc.bus_en);
            busy_cnt += int'(ifc.busy);
        end
        check("hold_len", 32'(en_cnt), 32'd4);
        check("busy_len", 32'(busy_cnt), 32'd7);

        // Reset asserted during the second HOLD cycle.
        ifc.req = 4'b0010;
        step();
        ifc.req = '0;
        step();
        rst = 1'b1;
        step();
        check("abort_en",   32'(ifc.bus_en), 32'h0);
        check("abort_busy", 32'(ifc.busy), 32'h0);
        rst = 1'b0;
        ifc.req = '1;
        step();
        check("post_rst_gnt", 32'(ifc.gnt), 32'h1);
        ifc.req = '0;
        for (int n = 0; n < 10; n++) step();

        // Requesters 0 and 3 held high.
        ifc.req = 4'b1001;
        prev_id = -1;
        for (int n = 0; n < 40; n++) begin
            step();
            gid(id);
            if (id >= 0) begin
`ifdef SYNC_BUS_PRIO_EN
                check("prio_id", 32'(id), 32'd0);
`else
                if (prev_id >= 0) check("alt_id", 32'(id), 32'(prev_id == 0 ? 3 : 0));
`endif
                prev_id = id;
            end
        end
        ifc.req = '0;
        for (int n = 0; n < 10; n++) step();

        // Random traffic with occasional resets; requesters hold until granted.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < NR; i++) begin
                if (ifc.req[i] && m_gnt[i]) begin
                    ifc.req[i] = 1'($urandom_range(0, 1));
                    ifc.req_data[i*DW +: DW] = DW'($urandom);
                end else if (!ifc.req[i] && $urandom_range(0, 2) == 0) begin
                    ifc.req[i] = 1'b1;
                    ifc.req_data[i*DW +: DW] = DW'($urandom);
                end
            end
            step();
        end
        rst = 1'b0;
        ifc.req = '0;
        for (int n = 0; n < 20; n++) step();

        // Loopback: 16 random words through the slower-clock synchronizer.
        tx_q.delete();
        rx_q.delete();
        issued = 0;
        for (int n = 0; n < 300 && (issued < 16 || ifc.req != '0); n++) begin
            for (int i = 0; i < NR; i++) if (ifc.req[i] && m_gnt[i]) ifc.req[i] = 1'b0;
            if (issued < 16 && $urandom_range(0, 1) == 1) begin
                int r;
                r = $urandom_range(0, NR - 1);
                if (!ifc.req[r]) begin
                    ifc.req[r] = 1'b1;
                    ifc.req_data[r*DW +: DW] = DW'($urandom);
                    issued++;
                end
            end
            step();
        end
        check("lb_issued", 32'(issued), 32'd16);
        check("lb_req_drained", 32'(ifc.req), 32'h0);
        for (int n = 0; n < 40; n++) step();
        check("lb_tx_count", 32'(tx_q.size()), 32'd16);
        check("lb_rx_count", 32'(rx_q.size()), 32'd16);
        for (int i = 0; i < rx_q.size() && i < tx_q.size(); i++) begin
            check("lb_word", 32'(rx_q[i]), 32'(tx_q[i]));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
